// File: rtl/result_sender_pkg.sv
// result_sender_pkg: shared FSM encoding and byte-count helper for the result serializer
package result_sender_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam int WCNT_W = 12;

    function automatic int calc_bpw(input int d_wl);
        return (d_wl + 7) / 8;
    endfunction

endpackage

// File: rtl/result_sender_word_fifo.sv
// word_fifo: synchronous show-ahead FIFO with occupancy count
module word_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    // A push into a full FIFO is still taken when the same cycle frees a slot
    always_comb begin
        do_rd    = pop && (count_q != '0);
        do_wr    = push && ((count_q != (AW+1)'(DEPTH)) || do_rd);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

endmodule

// File: rtl/result_sender.sv
// result_sender: buffers result words and streams them MSB-first as bytes to a UART
module result_sender
    import result_sender_pkg::*;
#(
    parameter int D_WL        = 24,
    parameter int OUTPUT_SIZE = 20,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_i_valid,
    input  logic [D_WL-1:0] d_i,
    output logic            d_i_ready,
    output logic [7:0]      tx_data,
    output logic            tx_en,
    input  logic            tx_finish,
    output logic            busy,
    output logic            frame_done
);

    localparam int BPW = calc_bpw(D_WL);
    localparam int SW  = 8 * BPW;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [D_WL-1:0]     fifo_rdata;
    logic [CW-1:0]       fifo_count;
    logic                last_byte, last_word;

    assign fifo_push = d_i_valid && d_i_ready;

    word_fifo #(
        .WIDTH (D_WL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (d_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign last_byte = byte_cnt_q == 3'(BPW - 1);
    assign last_word = word_cnt_q == WCNT_W'(OUTPUT_SIZE - 1);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        unique case (state_q)
            IDLE: state_d = fifo_empty ? IDLE : LOAD;
            LOAD: begin
                fifo_pop   = 1'b1;
                shift_d    = SW'(fifo_rdata);
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: begin
                // Shifting on the final byte too leaves tx_data at zero once idle
                if (tx_finish) begin
                    shift_d = shift_q << 8;
                    if (!last_byte) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = SEND;
                    end else begin
                        word_cnt_d   = last_word ? '0 : word_cnt_q + WCNT_W'(1);
                        frame_done_d = last_word;
                        state_d      = fifo_empty ? IDLE : LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_en      = state_q == SEND;
    assign tx_data    = shift_q[SW-1 -: 8];
    assign busy       = (fifo_count != '0) || (state_q != IDLE);
    assign d_i_ready  = !fifo_full;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_sender.sv
// tb_result_sender: scoreboard bench for two result_sender configurations with a UART model
module tb_result_sender;

    typedef struct {
        logic [7:0] b;
        int         pos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld  [2];
    logic [23:0] din  [2];
    logic        rdy  [2];
    logic [7:0]  txd  [2];
    logic        ten  [2];
    logic        tfin [2];
    logic        bsy  [2];
    logic        fd   [2];

    exp_t expq    [2][$];
    int   ten_log [2][$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pend [2];
    bit   stall [2];
    bit   spur [2];
    bit   inflight [2];
    bit   fd_exp [2];
    bit   fin_valid [2];
    bit   chk_across [2];
    int   fin_cnt [2];
    int   fin_cyc [2];
    int   fd_cnt [2];
    logic [7:0] last_b [2];
    int   lat_lo = 10;
    int   lat_hi = 10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    result_sender #(.D_WL(24), .OUTPUT_SIZE(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .d_i_valid(vld[0]), .d_i(din[0]), .d_i_ready(rdy[0]),
        .tx_data(txd[0]), .tx_en(ten[0]), .tx_finish(tfin[0]), .busy(bsy[0]), .frame_done(fd[0])
    );

    result_sender #(.D_WL(20), .OUTPUT_SIZE(3), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .d_i_valid(vld[1]), .d_i(din[1][19:0]), .d_i_ready(rdy[1]),
        .tx_data(txd[1]), .tx_en(ten[1]), .tx_finish(tfin[1]), .busy(bsy[1]), .frame_done(fd[1])
    );

    function automatic int frame_bytes(input int k);
        return k == 0 ? 4 * 3 : 3 * 3;
    endfunction

    task automatic check(input bit ok, input string nm, input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: a word becomes BPW bytes of its zero-extended value, MSB first
    function automatic void model_push(input int k, input logic [23:0] w);
        logic [23:0] m;
        exp_t e;
        m = (k == 0) ? w : (w & 24'h0FFFFF);
        for (int b = 2; b >= 0; b--) begin
            e.b   = m[8*b +: 8];
            e.pos = 2 - b;
            expq[k].push_back(e);
        end
    endfunction

    task automatic push(input int k, input logic [23:0] w, output bit acc);
        vld[k] = 1'b1;
        din[k] = w;
        acc = rdy[k];
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
        if (acc) model_push(k, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_checks();
        for (int k = 0; k < 2; k++) begin
            check(ten[k] == 1'b0, "rst_tx_en", ten[k], 0);
            check(txd[k] == 8'h00, "rst_tx_data", txd[k], 0);
            check(fd[k] == 1'b0, "rst_frame_done", fd[k], 0);
            check(bsy[k] == 1'b0, "rst_busy", bsy[k], 0);
            check(rdy[k] == 1'b1, "rst_ready", rdy[k], 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        @(posedge clk);
        #1;
        expq[0].delete();
        expq[1].delete();
        rst_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int k);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (expq[k].size() == 0 && !bsy[k] && !inflight[k]) done = 1'b1;
            else idle(1);
        end
        check(done, "drain_timeout", expq[k].size(), 0);
        idle(2);
    endtask

    // UART: finishes each byte a random number of cycles after its start strobe
    initial begin
        for (int k = 0; k < 2; k++) begin
            tfin[k] = 1'b0;
            pend[k] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                tfin[k] = 1'b0;
                if (rst) pend[k] = 0;
                else begin
                    if (spur[k]) begin
                        tfin[k] = 1'b1;
                        spur[k] = 1'b0;
                    end else if (pend[k] > 0 && !stall[k]) begin
                        pend[k]--;
                        if (pend[k] == 0) tfin[k] = 1'b1;
                    end
                    if (ten[k]) pend[k] = int'($urandom_range(lat_lo, lat_hi));
                end
            end
        end
    end

    // Monitor: compares each started byte and each frame_done against the model
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                inflight[k]  = 1'b0;
                fd_exp[k]    = 1'b0;
                fin_valid[k] = 1'b0;
                fin_cnt[k]   = 0;
            end else begin
                if (fd[k] || fd_exp[k]) begin
                    check(fd[k] == fd_exp[k], "frame_done", fd[k], fd_exp[k]);
                    if (fd[k]) fd_cnt[k]++;
                end
                fd_exp[k] = 1'b0;
                if (ten[k]) begin
                    ten_log[k].push_back(cyc);
                    check(expq[k].size() > 0, "byte_expected", expq[k].size(), 1);
                    if (expq[k].size() > 0) begin
                        e = expq[k].pop_front();
                        check(txd[k] == e.b, "byte", txd[k], e.b);
                        if (fin_valid[k] && e.pos != 0)
                            check(cyc - fin_cyc[k] == 1, "gap_in_word", cyc - fin_cyc[k], 1);
                        if (fin_valid[k] && e.pos == 0 && chk_across[k])
                            check(cyc - fin_cyc[k] == 2, "gap_across", cyc - fin_cyc[k], 2);
                        last_b[k] = e.b;
                    end
                    inflight[k] = 1'b1;
                end
                if (tfin[k] && inflight[k]) begin
                    check(txd[k] == last_b[k], "hold", txd[k], last_b[k]);
                    inflight[k]  = 1'b0;
                    fin_cyc[k]   = cyc;
                    fin_valid[k] = 1'b1;
                    fin_cnt[k]++;
                    if (fin_cnt[k] % frame_bytes(k) == 0) fd_exp[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        bit acc;
        bit a [2];
        int t0;
        int n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0;
            din[k] = '0;
            stall[k] = 1'b0;
            spur[k] = 1'b0;
            chk_across[k] = 1'b0;
            fd_cnt[k] = 0;
        end
        idle(3);
        rst_checks();
        rst = 1'b0;

        ten_log[0].delete();
        push(0, 24'hA1B2C3, acc);
        t0 = cyc;
        drain(0);
        check(ten_log[0].size() == 3, "single_count", ten_log[0].size(), 3);
        if (ten_log[0].size() > 0)
            check(ten_log[0][0] - t0 == 2, "first_latency", ten_log[0][0] - t0, 2);

        do_reset();
        n = fd_cnt[0];
        for (int w = 1; w <= 4; w++) begin
            push(0, 24'(w), acc);
            check(acc, "frame_accept", acc, 1);
        end
        chk_across[0] = 1'b1;
        drain(0);
        chk_across[0] = 1'b0;
        check(fd_cnt[0] - n == 1, "frame_count", fd_cnt[0] - n, 1);
        for (int w = 0; w < 4; w++) push(0, 24'($urandom), acc);
        drain(0);
        check(fd_cnt[0] - n == 2, "frame_wrap", fd_cnt[0] - n, 2);

        lat_lo = 1;
        lat_hi = 4;
        ten_log[0].delete();
        stall[0] = 1'b1;
        push(0, 24'($urandom), acc);
        idle(4);
        for (int i = 0; i < 6; i++) begin
            push(0, 24'($urandom), acc);
            check(acc == (i < 4), "full_accept", acc, i < 4);
        end
        check(rdy[0] == 1'b0, "full_ready", rdy[0], 0);
        stall[0] = 1'b0;
        drain(0);
        check(ten_log[0].size() == 15, "full_bytes", ten_log[0].size(), 15);

        ten_log[1].delete();
        push(1, 24'h0FFFFF, acc);
        drain(1);
        check(ten_log[1].size() == 3, "width_count", ten_log[1].size(), 3);

        stall[0] = 1'b1;
        for (int i = 0; i < 4; i++) push(0, 24'($urandom), acc);
        idle(3);
        check(bsy[0] == 1'b1, "pre_rst_busy", bsy[0], 1);
        do_reset();
        n = fd_cnt[0];
        ten_log[0].delete();
        push(0, 24'h123456, acc);
        drain(0);
        check(ten_log[0].size() == 3, "post_rst_count", ten_log[0].size(), 3);
        for (int i = 0; i < 3; i++) push(0, 24'($urandom), acc);
        drain(0);
        check(fd_cnt[0] - n == 1, "post_rst_frame", fd_cnt[0] - n, 1);

        ten_log[0].delete();
        spur[0] = 1'b1;
        idle(3);
        push(0, 24'($urandom), acc);
        drain(0);
        check(ten_log[0].size() == 3, "spurious_count", ten_log[0].size(), 3);

        lat_lo = 1;
        lat_hi = 5;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = ($urandom_range(0, 2) == 0);
                din[k] = 24'($urandom);
                a[k] = vld[k] && rdy[k];
            end
            idle(1);
            for (int k = 0; k < 2; k++) if (a[k]) model_push(k, din[k]);
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        drain(0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
